// File: rtl/store_pkg.sv
// Shared encodings for the store unit: request size codes, FSM states and
// the alignment rule applied at request acceptance.
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    FAULT = 3'd4
  } state_e;

  // True when the request cannot be performed: an illegal size code, a
  // halfword on an odd address, or a word that is not on a 4-byte boundary.
  function automatic logic misaligned_req(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Lane insertion for byte/halfword stores: the addressed lane(s) of the old
// memory word are replaced by the low bits of the store data, little-endian.
module store_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  // Replace the selected lane(s); anything not a byte/half/word keeps the old word.
  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: begin
        case (addr_lo)
          2'd0:    merged[7:0]   = new_data[7:0];
          2'd1:    merged[15:8]  = new_data[7:0];
          2'd2:    merged[23:16] = new_data[7:0];
          default: merged[31:24] = new_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo[1]) merged[31:16] = new_data[15:0];
        else            merged[15:0]  = new_data[15:0];
      end
      SZ_WORD: merged = new_data;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Narrows 32-bit register data into byte/halfword/word stores for a
// word-wide memory without byte enables. Sub-word stores are done as
// read-modify-write; misaligned or illegal requests fault without any
// memory access.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request, no memory activity
// READ  | read strobe to the captured word address
// MERGE | read data arrives, selected lane(s) merged into merge_q
// WRITE | write strobe, done pulse, completed-store count advances
// FAULT | done + misaligned pulse, memory untouched
module store_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              misaligned,
  output logic [CNT_W-1:0]  store_count
);

  state_e            state;
  state_e            state_nxt;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       merge_q;
  logic [31:0]       merged;
  logic [CNT_W-1:0]  count_q;
  logic              accept;

  assign accept = req_valid && (state == IDLE);

  store_merge u_merge (
    .old_word (mem_rdata),
    .new_data (data_q),
    .size     (size_q),
    .addr_lo  (addr_q[1:0]),
    .merged   (merged)
  );

  // State register; reset wins over any request seen in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Latch the request on acceptance; req_* are ignored until the next IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      size_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      size_q <= req_size;
      addr_q <= req_addr;
      data_q <= req_data;
    end
  end

  // Memory data is only meaningful in MERGE, so that is the sole capture point.
  always_ff @(posedge clk) begin
    if (reset)                merge_q <= '0;
    else if (state == MERGE)  merge_q <= merged;
  end

  // Count every completed write; wraps naturally at the counter width.
  always_ff @(posedge clk) begin
    if (reset)               count_q <= '0;
    else if (state == WRITE) count_q <= count_q + 1'b1;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned_req(req_size, req_addr[1:0])) state_nxt = FAULT;
          else if (req_size == SZ_WORD)                state_nxt = WRITE;
          else                                         state_nxt = READ;
        end
      end
      READ:    state_nxt = MERGE;
      MERGE:   state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      FAULT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state only; no path from req_* to outputs.
  always_comb begin
    req_ready  = 1'b0;
    mem_addr   = '0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_wdata  = '0;
    done       = 1'b0;
    misaligned = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_q[ADDR_W-1:2];
      end
      MERGE: mem_addr = addr_q[ADDR_W-1:2];
      WRITE: begin
        mem_addr  = addr_q[ADDR_W-1:2];
        mem_wr_en = 1'b1;
        mem_wdata = (size_q == SZ_WORD) ? data_q : merge_q;
        done      = 1'b1;
      end
      FAULT: begin
        done       = 1'b1;
        misaligned = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

  assign store_count = count_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a 2-bit store counter so wrap-around is
// reached quickly. A one-cycle-latency memory model returns a poison value
// whenever no read was strobed, so a mistimed capture shows up as bad data.
module tb_store_unit;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              misaligned;
  logic [CNT_W-1:0]  store_count;

  logic [31:0] rd_value;
  int          n_checks;
  int          n_errors;
  int          exp_cnt;

  store_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_size    (req_size),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rdata   (mem_rdata),
    .mem_wr_en   (mem_wr_en),
    .mem_wdata   (mem_wdata),
    .done        (done),
    .misaligned  (misaligned),
    .store_count (store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data valid exactly one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= rd_value;
    else           mem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_exp();
    return 32'(exp_cnt % 4);
  endfunction

  // Present a request for one accept edge, then scramble the inputs.
  task automatic start(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_size  = sz;
    req_addr  = a;
    req_data  = d;
    cyc();
    req_valid = 1'b0;
    req_size  = 2'b11;
    req_addr  = 32'hFFFF_FFFF;
    req_data  = 32'h5555_5555;
  endtask

  task automatic do_rmw(input string tag, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] old, input logic [31:0] exp_w);
    rd_value = old;
    check({tag, " idle ready"}, {31'b0, req_ready}, 32'd1);
    start(sz, a, d);
    check({tag, " c1 rd_en"}, {31'b0, mem_rd_en}, 32'd1);
    check({tag, " c1 addr"}, {2'b0, mem_addr}, a >> 2);
    check({tag, " c1 wr/done"}, {30'b0, mem_wr_en, done}, 32'd0);
    cyc();
    check({tag, " c2 strobes"}, {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
    check({tag, " c2 addr"}, {2'b0, mem_addr}, a >> 2);
    cyc();
    check({tag, " c3 wr/done/mis"}, {29'b0, mem_wr_en, done, misaligned}, 32'd6);
    check({tag, " c3 wdata"}, mem_wdata, exp_w);
    check({tag, " c3 addr"}, {2'b0, mem_addr}, a >> 2);
    exp_cnt++;
    cyc();
    check({tag, " after ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, " after count"}, {30'b0, store_count}, cnt_exp());
    check({tag, " after addr/wdata"}, {2'b0, mem_addr} | mem_wdata, 32'd0);
  endtask

  task automatic do_sw(input string tag, input logic [31:0] a, input logic [31:0] d);
    start(2'b10, a, d);
    check({tag, " c1 wr/rd/done"}, {29'b0, mem_wr_en, mem_rd_en, done}, 32'd5);
    check({tag, " c1 wdata"}, mem_wdata, d);
    check({tag, " c1 addr"}, {2'b0, mem_addr}, a >> 2);
    exp_cnt++;
    cyc();
    check({tag, " after count"}, {30'b0, store_count}, cnt_exp());
    check({tag, " after ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic do_fault(input string tag, input logic [1:0] sz, input logic [31:0] a);
    start(sz, a, 32'h1234_5678);
    check({tag, " c1 done/mis"}, {30'b0, done, misaligned}, 32'd3);
    check({tag, " c1 strobes"}, {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
    check({tag, " c1 addr"}, {2'b0, mem_addr}, 32'd0);
    cyc();
    check({tag, " after ready/done"}, {30'b0, req_ready, done}, 32'd2);
    check({tag, " after count"}, {30'b0, store_count}, cnt_exp());
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_cnt   = 0;
    rd_value  = 32'h0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_size  = 2'b00;
    req_addr  = '0;
    req_data  = '0;
    cyc();
    cyc();
    reset = 1'b0;

    check("reset ready", {31'b0, req_ready}, 32'd1);
    check("reset strobes", {28'b0, mem_rd_en, mem_wr_en, done, misaligned}, 32'd0);
    check("reset addr", {2'b0, mem_addr}, 32'd0);
    check("reset wdata", mem_wdata, 32'd0);
    check("reset count", {30'b0, store_count}, 32'd0);

    do_rmw("sb 0x101", 2'b00, 32'h0000_0101, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_DD44);
    do_rmw("sh 0x102", 2'b01, 32'h0000_0102, 32'h0000_BEEF, 32'h1122_3344, 32'hBEEF_3344);
    do_rmw("sh 0x100", 2'b01, 32'h0000_0100, 32'h0000_BEEF, 32'h1122_3344, 32'h1122_BEEF);
    do_sw("sw 0x100", 32'h0000_0100, 32'hCAFE_F00D);
    do_fault("flt sh 0x103", 2'b01, 32'h0000_0103);
    do_fault("flt sw 0x102", 2'b10, 32'h0000_0102);
    do_fault("flt size11", 2'b11, 32'h0000_0100);
    do_rmw("sb 0x203", 2'b00, 32'h0000_0203, 32'h0000_005A, 32'h1122_3344, 32'h5A22_3344);
    do_rmw("sb 0x200", 2'b00, 32'h0000_0200, 32'hFFFF_FF77, 32'h1122_3344, 32'h1122_3377);

    // Reset while in MERGE must cancel the pending write.
    rd_value = 32'h1122_3344;
    start(2'b00, 32'h0000_0101, 32'hAABB_CCDD);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_cnt = 0;
    check("rst merge wr_en", {31'b0, mem_wr_en}, 32'd0);
    check("rst merge ready", {31'b0, req_ready}, 32'd1);
    check("rst merge count", {30'b0, store_count}, 32'd0);
    cyc();
    check("rst merge wr_en later", {30'b0, mem_wr_en, done}, 32'd0);
    do_rmw("sb after rst", 2'b00, 32'h0000_0101, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_DD44);

    // A request presented together with reset is not accepted.
    reset     = 1'b1;
    req_valid = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h0000_0100;
    req_data  = 32'h0BAD_0BAD;
    cyc();
    reset     = 1'b0;
    req_valid = 1'b0;
    exp_cnt   = 0;
    check("rst+valid idle", {29'b0, req_ready, mem_wr_en, done}, 32'd4);
    cyc();
    check("rst+valid still idle", {29'b0, req_ready, mem_wr_en, done}, 32'd4);
    check("rst+valid count", {30'b0, store_count}, 32'd0);

    // Five back-to-back word stores with valid held high: count wraps at 4.
    req_valid = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h0000_0100;
    req_data  = 32'h1000_0000;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("b2b%0d write", i), {29'b0, mem_wr_en, done, req_ready}, 32'd6);
      check($sformatf("b2b%0d wdata", i), mem_wdata, 32'h1000_0000 + 32'(i));
      req_data = 32'h1000_0000 + 32'(i + 1);
      if (i == 4) req_valid = 1'b0;
      exp_cnt++;
      cyc();
      check($sformatf("b2b%0d ready", i), {30'b0, req_ready, mem_wr_en}, 32'd2);
      check($sformatf("b2b%0d count", i), {30'b0, store_count}, cnt_exp());
    end
    cyc();
    check("b2b final idle", {29'b0, req_ready, mem_wr_en, done}, 32'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
